// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-lite definitions for the SRAM responder and its helpers:
//   htrans_e    - transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   HSIZE_*     - transfer size encodings that the responders support
//   HRESP_*     - response encodings
//   slv_state_e - responder data-phase state machine
// ----------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slv_state_e;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// ----------------------------------------------------------------------------
// ahb_byte_lane_decode
// Combinational decode of an AHB transfer size and the low address bits into
// the byte lanes touched on a 32-bit data bus, plus an alignment flag.
//   hsize      in  3  transfer size (byte/half/word; larger sizes give be = 0)
//   addr       in  2  byte offset within the word
//   be         out 4  byte-lane enables, bit n = hwdata[8n+7:8n]
//   misaligned out 1  address not aligned to the transfer size
// Oversize transfers are not flagged here; the caller checks hsize itself.
// ----------------------------------------------------------------------------
import ahb_pkg::*;

module ahb_byte_lane_decode (
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] be,
    output logic       misaligned
);

    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                be = 4'b0001 << addr;
            end
            HSIZE_HALF: begin
                be         = addr[1] ? 4'b1100 : 4'b0011;
                misaligned = addr[0];
            end
            HSIZE_WORD: begin
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            default: begin
                be         = 4'b0000;
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
// AHB-lite responder backed by a single-port 32-bit word SRAM with byte-lane
// writes and a fixed number of wait states per OKAY data phase. Misaligned,
// oversize and out-of-range transfers get the two-cycle ERROR response.
// Parameters:
//   ADDR_WIDTH  log2 of memory depth in words
//   WAIT_STATES hreadyout-low cycles per OKAY data phase (0..15)
// Ports:
//   clk, reset (synchronous, active-low)
//   hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready  - bus inputs
//   hreadyout, hresp, hr_data                                 - responder outputs
// ----------------------------------------------------------------------------
import ahb_pkg::*;

module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hr_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int AW2   = ADDR_WIDTH + 2;   // byte-address bits inside the memory
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    slv_state_e       state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [AW2-1:0]   addr_reg;
    logic [2:0]       size_reg;
    logic             write_reg;

    logic [31:0]      rd_raw_reg;
    logic [3:0]       byp_be_reg;
    logic [31:0]      byp_data_reg;
    logic [31:0]      rd_word;

    logic [3:0]       unused_addr_be;
    logic             unused_data_mis;
    logic             unused_bits;
    logic             addr_misaligned;
    logic [3:0]       data_be;

    logic             can_accept;
    logic             accept;
    logic             addr_err;
    logic             wr_commit;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;

    assign unused_bits = &{1'b0, hprot, htrans[0]};

    // Alignment of the address-phase request.
    ahb_byte_lane_decode u_addr_decode (
        .hsize      (hsize),
        .addr       (haddr[1:0]),
        .be         (unused_addr_be),
        .misaligned (addr_misaligned)
    );

    // Byte lanes of the transfer currently in its data phase.
    ahb_byte_lane_decode u_data_decode (
        .hsize      (size_reg),
        .addr       (addr_reg[1:0]),
        .be         (data_be),
        .misaligned (unused_data_mis)
    );

    // A new address phase can only be taken while this responder is not stalling.
    assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DATA) || (state_reg == S_ERR2);
    assign accept     = hsel && hready && htrans[1] && can_accept;
    assign addr_err   = addr_misaligned || (hsize > HSIZE_WORD) || (|haddr[31:AW2]);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE, S_DATA, S_ERR2: begin
                if (accept) begin
                    if (addr_err) begin
                        state_next = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = S_DATA;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_DATA;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_ERR1: begin
                state_next = S_ERR2;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= '0;
            size_reg  <= 3'd0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg  <= haddr[AW2-1:0];
                size_reg  <= hsize;
                write_reg <= hwrite;
            end
        end
    end

    // Errored transfers never reach S_DATA, so they can never write.
    assign wr_commit = (state_reg == S_DATA) && write_reg;
    assign wr_idx    = addr_reg[AW2-1:2];

    always_ff @(posedge clk) begin
        if (reset && wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) begin
                    mem[wr_idx][b*8 +: 8] <= hwdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read: the word is fetched on the edge that enters S_DATA.
    // With zero wait states that is the acceptance edge itself, so the index
    // comes straight from haddr; otherwise the captured address is re-read
    // every wait cycle.
    assign rd_idx = accept ? haddr[AW2-1:2] : addr_reg[AW2-1:2];

    always_ff @(posedge clk) begin
        rd_raw_reg <= mem[rd_idx];
    end

    // A write committing on the same edge as the read fetch is not yet visible
    // in the array output, so its enabled lanes are forwarded alongside.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byp_be_reg   <= 4'b0000;
            byp_data_reg <= 32'd0;
        end else begin
            byp_be_reg   <= (wr_commit && (wr_idx == rd_idx)) ? data_be : 4'b0000;
            byp_data_reg <= hwdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_merge
            assign rd_word[gi*8 +: 8] = byp_be_reg[gi] ? byp_data_reg[gi*8 +: 8]
                                                       : rd_raw_reg[gi*8 +: 8];
        end
    endgenerate

    assign hreadyout = !((state_reg == S_WAIT) || (state_reg == S_ERR1));
    assign hresp     = ((state_reg == S_ERR1) || (state_reg == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign hr_data   = ((state_reg == S_DATA) && !write_reg) ? rd_word : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_sram_slave
// Directed bench for ahb_sram_slave. Instance A uses two wait states, instance
// B uses zero wait states for pipelined traffic; both share the bus signals
// and reset but have separate selects.
// ----------------------------------------------------------------------------
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel_a, hsel_b;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        stall_a;
    logic        hready_a, hready_b;
    logic        ready_a, resp_a, ready_b, resp_b;
    logic [31:0] rdata_a, rdata_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd;
    logic        rsp;
    logic        low_rsp;
    int          waits;

    always #5 clk = ~clk;

    assign hready_a = ready_a & ~stall_a;
    assign hready_b = ready_b;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut_a (
        .clk(clk), .reset(reset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready_a),
        .hreadyout(ready_a), .hresp(resp_a), .hr_data(rdata_a)
    );

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .reset(reset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hready_b),
        .hreadyout(ready_b), .hresp(resp_b), .hr_data(rdata_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_idle();
        hsel_a = 1'b0; hsel_b = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr  = 32'd0; hsize = 3'd0;
    endtask

    // Single transfer on instance A. Starts and ends just after a rising edge.
    task automatic xfer_a(input logic [31:0] a, input logic w, input logic [2:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd_o,
                          output logic rsp_o, output int waits_o, output logic low_rsp_o);
        logic done;
        hsel_a = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
        @(posedge clk); #1;
        bus_idle();
        hwdata    = wd;
        waits_o   = 0;
        low_rsp_o = 1'b0;
        rd_o      = 32'd0;
        rsp_o     = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                @(negedge clk);
                if (ready_a) begin
                    rd_o  = rdata_a;
                    rsp_o = resp_a;
                    done  = 1'b1;
                end else begin
                    waits_o++;
                    low_rsp_o = resp_a;
                end
            end
        end
        if (!done) check("xfer_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; stall_a = 1'b0; hprot = 4'b0011; hwdata = 32'd0;
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hreadyout", 32'(ready_a), 32'd1);
        check("reset_hresp",     32'(resp_a),  32'd0);
        check("reset_hr_data",   rdata_a,      32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 1. Pre-load word 0, then reset mid-write while in WAIT.
        xfer_a(32'h0, 1'b1, 3'd2, 32'h11223344, rd, rsp, waits, low_rsp);
        check("preload_waits", 32'(waits), 32'd2);
        hsel_a = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'hCAFEF00D;
        @(negedge clk);
        check("midwrite_in_wait", 32'(ready_a), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_hreadyout", 32'(ready_a), 32'd1);
        check("rst_mid_hresp",     32'(resp_a),  32'd0);
        check("rst_mid_hr_data",   rdata_a,      32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xfer_a(32'h0, 1'b0, 3'd2, 32'h0, rd, rsp, waits, low_rsp);
        check("rst_no_write_read", rd, 32'h11223344);

        // 2. Two wait states on write and read.
        xfer_a(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rd, rsp, waits, low_rsp);
        check("ws2_write_waits", 32'(waits), 32'd2);
        check("ws2_write_resp",  32'(rsp),   32'd0);
        xfer_a(32'h10, 1'b0, 3'd2, 32'h0, rd, rsp, waits, low_rsp);
        check("ws2_read_waits", 32'(waits), 32'd2);
        check("ws2_read_data",  rd,         32'hDEADBEEF);

        // 3. Byte and half-word lanes.
        xfer_a(32'h20, 1'b1, 3'd2, 32'h00000000, rd, rsp, waits, low_rsp);
        xfer_a(32'h21, 1'b1, 3'd0, 32'h0000AA00, rd, rsp, waits, low_rsp);
        xfer_a(32'h22, 1'b1, 3'd1, 32'h55660000, rd, rsp, waits, low_rsp);
        xfer_a(32'h20, 1'b0, 3'd2, 32'h0, rd, rsp, waits, low_rsp);
        check("lanes_read", rd, 32'h5566AA00);

        // 4. Misaligned and oversize writes leave memory untouched.
        xfer_a(32'h4, 1'b1, 3'd2, 32'h12345678, rd, rsp, waits, low_rsp);
        xfer_a(32'h6, 1'b1, 3'd2, 32'hFFFFFFFF, rd, rsp, waits, low_rsp);
        check("misal_err_cycles", 32'(waits),   32'd1);
        check("misal_err1_resp",  32'(low_rsp), 32'd1);
        check("misal_err2_resp",  32'(rsp),     32'd1);
        xfer_a(32'h4, 1'b1, 3'd3, 32'hFFFFFFFF, rd, rsp, waits, low_rsp);
        check("oversize_err_cycles", 32'(waits),   32'd1);
        check("oversize_err1_resp",  32'(low_rsp), 32'd1);
        check("oversize_err2_resp",  32'(rsp),     32'd1);
        xfer_a(32'h4, 1'b0, 3'd2, 32'h0, rd, rsp, waits, low_rsp);
        check("err_mem_unchanged", rd,         32'h12345678);
        check("ok_after_err_resp", 32'(rsp),   32'd0);

        // 6. Out of range, idle-type cycles and foreign stall.
        xfer_a(32'h1000, 1'b0, 3'd2, 32'h0, rd, rsp, waits, low_rsp);
        check("range_err_resp",   32'(rsp),   32'd1);
        check("range_err_cycles", 32'(waits), 32'd1);
        hsel_a = 1'b1; haddr = 32'h10; htrans = 2'b01; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("busy_ready",   32'(ready_a), 32'd1);
        check("busy_resp",    32'(resp_a),  32'd0);
        check("busy_hr_data", rdata_a,      32'd0);
        @(posedge clk); #1;
        hsel_a = 1'b0; haddr = 32'h10; htrans = 2'b10; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("nosel_ready",   32'(ready_a), 32'd1);
        check("nosel_hr_data", rdata_a,      32'd0);
        @(posedge clk); #1;
        stall_a = 1'b1;
        hsel_a = 1'b1; haddr = 32'h10; htrans = 2'b10; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        stall_a = 1'b0;
        @(negedge clk);
        check("stall_no_accept_ready", 32'(ready_a), 32'd1);
        check("stall_no_accept_resp",  32'(resp_a),  32'd0);
        @(posedge clk); #1;

        // 5. Zero wait states, pipelined writes then reads on instance B.
        hsel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0;
        @(posedge clk); #1;
        htrans = 2'b11; haddr = 32'h4; hwdata = 32'hA0A0A0A0;
        @(negedge clk);
        check("pipe_w0_ready", 32'(ready_b), 32'd1);
        @(posedge clk); #1;
        haddr = 32'h8; hwdata = 32'hB1B1B1B1;
        @(negedge clk);
        check("pipe_w1_ready", 32'(ready_b), 32'd1);
        @(posedge clk); #1;
        bus_idle(); hwdata = 32'hC2C2C2C2;
        @(negedge clk);
        check("pipe_w2_ready", 32'(ready_b), 32'd1);
        check("pipe_w2_resp",  32'(resp_b),  32'd0);
        @(posedge clk); #1;
        hsel_b = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h0;
        @(posedge clk); #1;
        htrans = 2'b11; haddr = 32'h4;
        @(negedge clk);
        check("pipe_r0_data", rdata_b, 32'hA0A0A0A0);
        @(posedge clk); #1;
        haddr = 32'h8;
        @(negedge clk);
        check("pipe_r1_data", rdata_b, 32'hB1B1B1B1);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("pipe_r2_data", rdata_b, 32'hC2C2C2C2);
        check("pipe_r2_ready", 32'(ready_b), 32'd1);
        @(posedge clk); #1;

        // Read immediately after a write to the same word.
        hsel_b = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'hC;
        @(posedge clk); #1;
        hwrite = 1'b0; hwdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("raw_bypass_data", rdata_b, 32'hA5A5A5A5);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
